// File: rtl/crono_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : crono_pkg
//  Description : Shared constants for the chronometer controller: state
//                encoding, time-field limits/width and a saturation helper.
//                Optional feature macro used by this slice:
//                CRONO_AUTORELOAD_EN (reload last programmed interval).
//  Revision    : 1.0 - initial release
// ============================================================================
package crono_pkg;

    // Width of every HH/MM/SS field
    localparam int TIME_W = 8;

    // Controller state encoding (visible on the state output)
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] EDIT  = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] RUN   = 3'd3;
    localparam logic [2:0] PAUSE = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    // Field limits used both for clamping and for borrow reload
    localparam logic [TIME_W-1:0] SEC_MAX = 8'd59;
    localparam logic [TIME_W-1:0] MIN_MAX = 8'd59;

    // Saturate a field value to an upper limit
    function automatic logic [TIME_W-1:0] sat_max(input logic [TIME_W-1:0] v,
                                                  input logic [TIME_W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/crono_hms_dec.sv
`default_nettype none
// ============================================================================
//  Module      : crono_hms_dec
//  Description : Combinational HH:MM:SS decrement-by-one with borrow chain,
//                plus zero flags for the input value and for the result.
//  Revision    : 1.0 - initial release
// ============================================================================
module crono_hms_dec
    import crono_pkg::*;
(
    input  logic [TIME_W-1:0] i_h,
    input  logic [TIME_W-1:0] i_m,
    input  logic [TIME_W-1:0] i_s,
    output logic [TIME_W-1:0] o_h,
    output logic [TIME_W-1:0] o_m,
    output logic [TIME_W-1:0] o_s,
    output logic              o_in_zero,
    output logic              o_dec_zero
);

    localparam logic [TIME_W-1:0] c_one  = TIME_W'(1);
    localparam logic [TIME_W-1:0] c_zero = '0;

    logic w_s_borrow;
    logic w_m_borrow;

    // Borrow chain: seconds wrap to 59 and borrow a minute, minutes likewise
    always_comb begin
        w_s_borrow = (i_s == c_zero);
        w_m_borrow = w_s_borrow && (i_m == c_zero);
        o_s        = w_s_borrow ? SEC_MAX : (i_s - c_one);
        o_m        = w_s_borrow ? ((i_m == c_zero) ? MIN_MAX : (i_m - c_one)) : i_m;
        o_h        = w_m_borrow ? (i_h - c_one) : i_h;
    end

    // Zero detection on the current count and on the decremented count
    always_comb begin
        o_in_zero  = (i_h == c_zero) && (i_m == c_zero) && (i_s == c_zero);
        o_dec_zero = (o_h == c_zero) && (o_m == c_zero) && (o_s == c_zero);
    end

endmodule
`default_nettype wire

// File: rtl/crono_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : crono_ctrl
//  Description : Chronometer (countdown) sequencing controller. Grants the
//                HH:MM:SS editor its enable, latches the edited value with
//                clamping, counts down on a 1 Hz tick and rings at zero.
//                Optional feature macro: CRONO_AUTORELOAD_EN - when defined,
//                leaving DONE reloads the last programmed interval from a
//                shadow register; when undefined no shadow exists.
//  Revision    : 1.0 - initial release
// ============================================================================
module crono_ctrl
    import crono_pkg::*;
#(
    parameter int HOUR_MAX  = 23,
    parameter int RING_SECS = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_1hz,
    input  logic              bt_start,
    input  logic              bt_edit,
    input  logic              bt_stop,
    input  logic [TIME_W-1:0] hcr_in,
    input  logic [TIME_W-1:0] mcr_in,
    input  logic [TIME_W-1:0] scr_in,
    output logic              edit_en,
    output logic [TIME_W-1:0] h_run,
    output logic [TIME_W-1:0] m_run,
    output logic [TIME_W-1:0] s_run,
    output logic              ring,
    output logic              busy,
    output logic [2:0]        state
);

    localparam int                c_rc_w     = $clog2(RING_SECS + 1);
    localparam logic [c_rc_w-1:0] c_rc_lim   = c_rc_w'(RING_SECS);
    localparam logic [c_rc_w-1:0] c_rc_one   = c_rc_w'(1);
    localparam logic [TIME_W-1:0] c_hour_max = TIME_W'(HOUR_MAX);

    // FSM state and registered outputs
    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic              r_edit_en;
    logic              r_ring;
    logic              r_busy;
    logic              w_edit_en_nxt;
    logic              w_ring_nxt;
    logic              w_busy_nxt;

    // Countdown datapath
    logic [TIME_W-1:0] r_h;
    logic [TIME_W-1:0] r_m;
    logic [TIME_W-1:0] r_s;
    logic [TIME_W-1:0] w_h_nxt;
    logic [TIME_W-1:0] w_m_nxt;
    logic [TIME_W-1:0] w_s_nxt;
    logic [TIME_W-1:0] w_h_dec;
    logic [TIME_W-1:0] w_m_dec;
    logic [TIME_W-1:0] w_s_dec;
    logic [TIME_W-1:0] w_ld_h;
    logic [TIME_W-1:0] w_ld_m;
    logic [TIME_W-1:0] w_ld_s;
    logic              w_cnt_zero;
    logic              w_dec_zero;

    // Ring duration counter
    logic [c_rc_w-1:0] r_rcnt;
    logic [c_rc_w-1:0] w_rcnt_nxt;
    logic [c_rc_w-1:0] w_rcnt_inc;
    logic              w_rc_expire;

    // Button edge detection
    logic              r_hist_start;
    logic              r_hist_edit;
    logic              r_hist_stop;
    logic              w_raw_start;
    logic              w_raw_edit;
    logic              w_stop_e;
    logic              w_edit_e;
    logic              w_start_e;

`ifdef CRONO_AUTORELOAD_EN
    logic [TIME_W-1:0] r_sh_h;
    logic [TIME_W-1:0] r_sh_m;
    logic [TIME_W-1:0] r_sh_s;
`endif

    crono_hms_dec u_dec (
        .i_h        (r_h),
        .i_m        (r_m),
        .i_s        (r_s),
        .o_h        (w_h_dec),
        .o_m        (w_m_dec),
        .o_s        (w_s_dec),
        .o_in_zero  (w_cnt_zero),
        .o_dec_zero (w_dec_zero)
    );

    // Rising edges with stop > edit > start; losers are dropped, not queued
    always_comb begin
        w_raw_start = bt_start & ~r_hist_start;
        w_raw_edit  = bt_edit  & ~r_hist_edit;
        w_stop_e    = bt_stop  & ~r_hist_stop;
        w_edit_e    = w_raw_edit  & ~w_stop_e;
        w_start_e   = w_raw_start & ~w_stop_e & ~w_raw_edit;
    end

    // Clamped editor values and ring-counter increment
    always_comb begin
        w_ld_h      = sat_max(hcr_in, c_hour_max);
        w_ld_m      = sat_max(mcr_in, MIN_MAX);
        w_ld_s      = sat_max(scr_in, SEC_MAX);
        w_rcnt_inc  = r_rcnt + c_rc_one;
        w_rc_expire = tick_1hz && (w_rcnt_inc == c_rc_lim);
    end

    // FSM state register with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_edit_en <= 1'b0;
            r_ring    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_edit_en <= w_edit_en_nxt;
            r_ring    <= w_ring_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // FSM next-state decode
    always_comb begin
        w_state_nxt = r_state;
        if (w_stop_e) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_edit_e)                       w_state_nxt = EDIT;
                         else if (w_start_e && !w_cnt_zero)  w_state_nxt = RUN;
                EDIT:    if (w_edit_e)                       w_state_nxt = LOAD;
                LOAD:                                        w_state_nxt = IDLE;
                RUN:     if (w_start_e)                      w_state_nxt = PAUSE;
                         else if (tick_1hz && w_dec_zero)    w_state_nxt = DONE;
                PAUSE:   if (w_start_e)                      w_state_nxt = RUN;
                         else if (w_edit_e)                  w_state_nxt = EDIT;
                DONE:    if (w_start_e || w_edit_e || w_rc_expire)
                                                             w_state_nxt = IDLE;
                default:                                     w_state_nxt = IDLE;
            endcase
        end
    end

    // FSM outputs and countdown/ring-counter next values
    always_comb begin
        w_edit_en_nxt = (w_state_nxt == EDIT);
        w_ring_nxt    = (w_state_nxt == DONE);
        w_busy_nxt    = (w_state_nxt == RUN) || (w_state_nxt == PAUSE);
        w_h_nxt       = r_h;
        w_m_nxt       = r_m;
        w_s_nxt       = r_s;
        w_rcnt_nxt    = r_rcnt;
        if (w_stop_e) begin
            w_h_nxt    = '0;
            w_m_nxt    = '0;
            w_s_nxt    = '0;
            w_rcnt_nxt = '0;
        end else begin
            case (r_state)
                LOAD: begin
                    w_h_nxt = w_ld_h;
                    w_m_nxt = w_ld_m;
                    w_s_nxt = w_ld_s;
                end
                RUN: begin
                    // A coincident start edge pauses instead of decrementing
                    if (!w_start_e && tick_1hz) begin
                        w_h_nxt = w_h_dec;
                        w_m_nxt = w_m_dec;
                        w_s_nxt = w_s_dec;
                        if (w_dec_zero) w_rcnt_nxt = '0;
                    end
                end
                DONE: begin
                    if (w_state_nxt == IDLE) begin
                        w_rcnt_nxt = '0;
`ifdef CRONO_AUTORELOAD_EN
                        w_h_nxt    = r_sh_h;
                        w_m_nxt    = r_sh_m;
                        w_s_nxt    = r_sh_s;
`endif
                    end else if (tick_1hz) begin
                        w_rcnt_nxt = w_rcnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Countdown value, ring counter and button history registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h          <= '0;
            r_m          <= '0;
            r_s          <= '0;
            r_rcnt       <= '0;
            r_hist_start <= 1'b0;
            r_hist_edit  <= 1'b0;
            r_hist_stop  <= 1'b0;
        end else begin
            r_h          <= w_h_nxt;
            r_m          <= w_m_nxt;
            r_s          <= w_s_nxt;
            r_rcnt       <= w_rcnt_nxt;
            r_hist_start <= bt_start;
            r_hist_edit  <= bt_edit;
            r_hist_stop  <= bt_stop;
        end
    end

`ifdef CRONO_AUTORELOAD_EN
    // Shadow of the last loaded interval; survives stop, refreshed on LOAD
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh_h <= '0;
            r_sh_m <= '0;
            r_sh_s <= '0;
        end else if ((r_state == LOAD) && !w_stop_e) begin
            r_sh_h <= w_ld_h;
            r_sh_m <= w_ld_m;
            r_sh_s <= w_ld_s;
        end
    end
`endif

    assign edit_en = r_edit_en;
    assign ring    = r_ring;
    assign busy    = r_busy;
    assign state   = r_state;
    assign h_run   = r_h;
    assign m_run   = r_m;
    assign s_run   = r_s;

endmodule
`default_nettype wire

// File: doc/crono_ctrl.md
Name: crono_ctrl

Overview:
Sequencing controller for the chronometer (countdown) function of the clock design.
- Grants the HH:MM:SS editor its enable (edit_en) and latches the edited value.
- Runs the countdown from a 1 Hz tick and raises the alarm (ring) at zero.
- Sits between the push-button conditioning and the display/RTC write-back mux.

Parameters:
HOUR_MAX, 23, maximum hour value accepted at load (clamp limit)
RING_SECS, 10, number of 1 Hz ticks ring stays asserted in DONE

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick_1hz  in  1  one-clk-wide pulse once per second
bt_start  in  1  level, debounced; rising edge = start/pause toggle
bt_edit  in  1  level, debounced; rising edge = enter/leave edit
bt_stop  in  1  level, debounced; rising edge = clear/abort
hcr_in  in  8  hours from editor, binary
mcr_in  in  8  minutes from editor, binary
scr_in  in  8  seconds from editor, binary
edit_en  out  1  enable to editor; high only in EDIT
h_run  out  8  current countdown hours, binary
m_run  out  8  current countdown minutes, binary
s_run  out  8  current countdown seconds, binary
ring  out  1  alarm, high in DONE while ring counter active
busy  out  1  high in RUN or PAUSE
state  out  3  current state encoding (debug/display select)

Behaviour:
- Reset (async, active-high): state=IDLE; h/m/s_run=0; edit_en=0; ring=0; busy=0; ring counter=0; all button history regs=0.
- Edge detection:
  - One history flop per button; edge = btn & ~hist; hist updates every clk.
  - Priority within a cycle: bt_stop > bt_edit > bt_start.
  - Lower-priority edges arriving in the same cycle are discarded, not queued.
- States, encoded 0..5:
  - IDLE=0, EDIT=1, LOAD=2, RUN=3, PAUSE=4, DONE=5.
- IDLE:
  - edit edge -> EDIT.
  - start edge with count != 0 -> RUN.
  - start edge with count == 0 -> stay IDLE.
- EDIT:
  - edit_en=1, registered, asserted the cycle after the transition.
  - edit edge -> LOAD, edit_en=0.
  - start edge ignored.
- LOAD (exactly 1 cycle):
  - Capture inputs with clamping: s = min(scr_in,59), m = min(mcr_in,59), h = min(hcr_in,HOUR_MAX).
  - Store the clamped value in the reload shadow register.
  - -> IDLE.
- RUN:
  - On tick_1hz, decrement with borrow chain: s-1; if s==0 then s=59 and m-1; if m==0 then m=59 and h-1.
  - If the post-decrement value is 00:00:00 -> DONE; ring=1; ring counter=0.
  - Start edge -> PAUSE.
  - Start edge and tick in the same cycle: PAUSE wins, no decrement.
  - The tick in the cycle RUN is entered is not applied.
- PAUSE: counts frozen; start edge -> RUN; edit edge -> EDIT (count retained, editor may modify it).
- DONE:
  - ring=1; each tick increments the ring counter.
  - When the counter reaches RING_SECS: ring=0, -> IDLE.
  - Start or edit edge acknowledges early: ring=0, -> IDLE.
- bt_stop edge in any state: -> IDLE; count=0; ring=0; edit_en=0. The reload shadow is kept.
- busy = (state==RUN) | (state==PAUSE), registered.
- Reset mid-RUN or mid-DONE: immediate async clear, same values as the reset line above.
- All arithmetic is 8-bit unsigned; values never exceed 59 / HOUR_MAX, so no overflow path exists.

Optional Feature:
CRONO_AUTORELOAD_EN
- Defined: on DONE -> IDLE (timeout or acknowledge), count is reloaded from the shadow register, so a start edge reruns the last programmed interval.
- Undefined: count stays 00:00:00 after DONE, and no shadow register is synthesized.
- bt_stop always clears to zero in both builds.

Decomposition:
- Package crono_pkg holds:
  - state encoding constants IDLE..DONE (3-bit);
  - SEC_MAX=59, MIN_MAX=59;
  - the 8-bit time-field width constant.
- Sub-module crono_hms_dec: combinational HH:MM:SS borrow-chain decrementer plus a zero flag. It is instantiated once; the FSM stays in crono_ctrl.

Test Plan:
- Reset mid-RUN at 00:05:30 -> all outputs 0, state=0 without waiting for a clk edge.
- Edit edge, then editor drives 01:02:75, then edit edge -> LOAD clamps to 01:02:59; state IDLE; edit_en high only during EDIT.
- Load 00:00:03, start, 3 ticks -> 00:00:02, 00:00:01, then DONE with ring=1; after RING_SECS=10 ticks ring=0 and state=IDLE.
- Load 01:00:00, start, 1 tick -> 00:59:59 (double borrow); start edge coincident with the next tick -> PAUSE, value stays 00:59:59.
- In RUN at 00:10:00, stop and start edges in the same cycle -> stop wins: IDLE, count 00:00:00, busy=0.
- Autoreload build: load 00:00:02, run to DONE, start edge acknowledges -> IDLE with 00:00:02. Non-autoreload build, same stimulus -> 00:00:00, and a further start edge stays in IDLE.
